// File: rtl/cache_mem_arbiter.sv
//------------------------------------------------------------------------------
// cache_mem_arbiter: shares one pmem port between I-cache and D-cache bursts.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cache_mem_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic [15:0]           grant_d_cnt,
    output logic [15:0]           grant_i_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_last_d;
    logic                  r_op_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic [15:0]           r_grant_d_cnt;
    logic [15:0]           r_grant_i_cnt;
    logic                  w_d_req;
    logic                  w_grant_d;
    logic                  w_grant_i;

    always_comb begin
        w_d_req      = d_pmem_read | d_pmem_write;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        w_state_next = r_state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (r_state)
            IDLE: begin
                // D wins unless both are pending and D had the previous grant
                if (w_d_req && (!i_pmem_read || !r_last_d)) begin
                    w_grant_d    = 1'b1;
                    w_state_next = SERVE_D;
                end else if (i_pmem_read) begin
                    w_grant_i    = 1'b1;
                    w_state_next = SERVE_I;
                end
            end
            SERVE_I: begin
                pmem_read   = 1'b1;
                i_pmem_resp = pmem_resp;
                if (pmem_resp) w_state_next = IDLE;
            end
            SERVE_D: begin
                pmem_read   = ~r_op_write;
                pmem_write  = r_op_write;
                d_pmem_resp = pmem_resp;
                if (pmem_resp) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_last_d      <= 1'b0;
            r_op_write    <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_grant_d_cnt <= '0;
            r_grant_i_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_d) begin
                r_addr     <= d_pmem_address;
                r_wdata    <= d_pmem_wdata;
                r_op_write <= d_pmem_write;
                r_last_d   <= 1'b1;
                if (r_grant_d_cnt != 16'hFFFF) r_grant_d_cnt <= r_grant_d_cnt + 16'd1;
            end
            if (w_grant_i) begin
                r_addr     <= i_pmem_address;
                r_op_write <= 1'b0;
                r_last_d   <= 1'b0;
                if (r_grant_i_cnt != 16'hFFFF) r_grant_i_cnt <= r_grant_i_cnt + 16'd1;
            end
        end
    end

    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
    assign grant_d_cnt  = r_grant_d_cnt;
    assign grant_i_cnt  = r_grant_i_cnt;

    // Simultaneous D read and write at grant is a caller protocol error
    a_no_rw_collision: assert property (@(posedge clk) disable iff (!rst)
        !(w_grant_d && d_pmem_read && d_pmem_write));

endmodule

`default_nettype wire

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Shares the single physical-memory port between the I-cache and D-cache miss/writeback paths of the pipelined RV32I core. It sits below both caches and above the cacheline adaptor/pmem. It grants one requester per burst, latches that requester's address and data, and routes the memory response back. Grant policy is D-cache priority with alternation when both requesters are pending, so the I-cache cannot starve.

Parameters:
LINE_WIDTH, 256, cacheline width in bits for rdata/wdata
ADDR_WIDTH, 32, physical address width

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low (asserted when 0)
i_pmem_read  input  1  I-cache line-fill request
i_pmem_address  input  ADDR_WIDTH  I-cache line address
i_pmem_rdata  output  LINE_WIDTH  fill data to I-cache
i_pmem_resp  output  1  I-cache completion pulse
d_pmem_read  input  1  D-cache line-fill request
d_pmem_write  input  1  D-cache writeback request
d_pmem_address  input  ADDR_WIDTH  D-cache line address
d_pmem_wdata  input  LINE_WIDTH  D-cache writeback line
d_pmem_rdata  output  LINE_WIDTH  fill data to D-cache
d_pmem_resp  output  1  D-cache completion pulse
pmem_read  output  1  read to memory
pmem_write  output  1  write to memory
pmem_address  output  ADDR_WIDTH  memory address
pmem_wdata  output  LINE_WIDTH  memory write line
pmem_rdata  input  LINE_WIDTH  memory read line
pmem_resp  input  1  memory completion, one-cycle pulse
grant_d_cnt  output  16  saturating count of D-cache grants
grant_i_cnt  output  16  saturating count of I-cache grants

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Internal regs: state, last_d (1 = last grant was D), latched addr/wdata/op.
- Reset (rst==0 at a clk edge): state=IDLE, last_d=0, latches=0, counters=0. All outputs are then 0: pmem_read, pmem_write, pmem_address, pmem_wdata, both resp outputs.
- Reset mid-burst: abort to IDLE. pmem_read/pmem_write drop the next cycle. No resp is forwarded.
- IDLE arbitration, evaluated each cycle:
  - d_req = d_pmem_read | d_pmem_write.
  - Only d_req → SERVE_D.
  - Only i_pmem_read → SERVE_I.
  - Both → SERVE_I if last_d==1, else SERVE_D.
  - Neither → stay in IDLE.
- On a grant edge:
  - Latch the granted address into pmem_address.
  - For D, latch d_pmem_wdata and the op. write wins if d_pmem_read and d_pmem_write are both high; this is a protocol error, flagged by an assertion in simulation.
  - Update last_d. Increment the matching counter, saturating at 16'hFFFF.
- Latency: request seen in IDLE at cycle t → pmem_read or pmem_write asserted at t+1. Outputs decode from state and latches, so they are glitch-free and stable for the whole burst.
- SERVE_x:
  - Hold pmem_read or pmem_write, pmem_address and pmem_wdata constant until pmem_resp.
  - Requester input changes are ignored while in SERVE_x.
- Response routing is combinational:
  - i_pmem_resp = pmem_resp & (state==SERVE_I).
  - d_pmem_resp = pmem_resp & (state==SERVE_D).
  - i_pmem_rdata and d_pmem_rdata both = pmem_rdata.
- On the pmem_resp cycle → IDLE, deasserting pmem_read/pmem_write at the next edge.
- One mandatory IDLE cycle follows each burst. A requester still holding its request in that IDLE cycle is re-arbitrated normally.
- pmem_resp received in IDLE is ignored; no resp is forwarded.
- A requester that drops its request while in SERVE_x does not abort the burst.

Test Plan:
- Reset: hold rst=0 for 2 cycles with both requests high → all outputs 0, state IDLE. Release: D granted first (last_d=0), pmem_write or pmem_read high at the 2nd edge after release.
- Lone I fill at addr 0x0000_0060: pmem_read=1 and pmem_address=0x60 one cycle after request. Memory returns resp after 5 cycles with rdata=256'hA5…A5 → i_pmem_resp pulses for exactly 1 cycle, d_pmem_resp stays 0, pmem_read drops next cycle, grant_i_cnt=1.
- Simultaneous: I read 0x100 and D writeback 0x200 (wdata pattern 0xDEAD…) raised in the same cycle → D serviced first with pmem_write=1 and addr 0x200. After resp and one IDLE cycle, I serviced at 0x100. Order D,I; each resp routed correctly.
- Fairness: both requesters re-request continuously for 6 bursts → grants alternate D,I,D,I,D,I; grant_d_cnt=3, grant_i_cnt=3.
- Stability: during SERVE_D change d_pmem_address to 0xFFFF_FFE0 and drop d_pmem_write → pmem_address and pmem_write hold their latched values until resp.
- Reset mid-burst: assert rst=0 two cycles into SERVE_I, then give pmem_resp → no i_pmem_resp, pmem_read=0, counters=0. Stray pmem_resp in IDLE → no resp forwarded.
